riscv_apu_resp: RTL



---
 rtl/riscv_apu_resp.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/riscv_apu_resp.sv
// rtl/riscv_apu_resp.sv - APU responder: req/gnt accept, small ALU, latency classes, in-order result FIFO
// Optional APU_RESP_FLAGS_EN adds per-entry zero/carry flags on apu_slave_flags_o.
module riscv_apu_resp #(
  parameter int WIDTH     = 32,
  parameter int MC_CYCLES = 4,
  parameter int DEPTH     = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             apu_slave_req_i,
  output logic             apu_slave_gnt_o,
  input  logic [1:0]       apu_slave_lat_i,
  input  logic [1:0]       apu_slave_op_i,
  input  logic [WIDTH-1:0] apu_slave_operand_a_i,
  input  logic [WIDTH-1:0] apu_slave_operand_b_i,
  output logic             apu_slave_valid_o,
  input  logic             apu_slave_ready_i,
  output logic [WIDTH-1:0] apu_slave_result_o,
`ifdef APU_RESP_FLAGS_EN
  output logic [1:0]       apu_slave_flags_o,
`endif
  output logic             busy_o
);

  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int MCW = $clog2(MC_CYCLES);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             s2_valid_q, s2_valid_d, mc_valid_q, mc_valid_d;
  logic [WIDTH-1:0] s2_data_q, s2_data_d, mc_data_q, mc_data_d;
  logic [MCW-1:0]   mc_cnt_q, mc_cnt_d;

  logic [WIDTH:0]   alu_ext;
  logic [CW:0]      occupancy;
  logic             order_ok, accept, pop, push;
  logic             push_direct, push_s2, push_mc;
  logic [WIDTH-1:0] push_data;

  // Top bit of alu_ext is carry for ADD and borrow for SUB.
  always_comb begin
    alu_ext = '0;
    case (apu_slave_op_i)
      2'd0:    alu_ext = {1'b0, apu_slave_operand_a_i} + {1'b0, apu_slave_operand_b_i};
      2'd1:    alu_ext = {1'b0, apu_slave_operand_a_i} - {1'b0, apu_slave_operand_b_i};
      2'd2:    alu_ext = {1'b0, apu_slave_operand_a_i ^ apu_slave_operand_b_i};
      default: alu_ext = {1'b0, apu_slave_operand_a_i & apu_slave_operand_b_i};
    endcase
  end

  always_comb begin
    occupancy = (CW+1)'(count_q) + (CW+1)'(s2_valid_q) + (CW+1)'(mc_valid_q);
    if (apu_slave_lat_i == 2'd2) order_ok = !mc_valid_q;
    else                         order_ok = !s2_valid_q && !mc_valid_q;
    apu_slave_gnt_o = apu_slave_req_i && (occupancy < (CW+1)'(DEPTH)) && order_ok;
    accept      = apu_slave_gnt_o;
    push_direct = accept && !apu_slave_lat_i[1];
    push_s2     = s2_valid_q;
    push_mc     = mc_valid_q && (mc_cnt_q == MCW'(1));
    push        = push_direct || push_s2 || push_mc;
    if (push_s2)      push_data = s2_data_q;
    else if (push_mc) push_data = mc_data_q;
    else              push_data = alu_ext[WIDTH-1:0];
    pop = (count_q != '0) && apu_slave_ready_i;
  end

  // A class-2 accept may reload s2 on the same edge its previous content pushes.
  always_comb begin
    s2_valid_d = accept && (apu_slave_lat_i == 2'd2);
    s2_data_d  = s2_valid_d ? alu_ext[WIDTH-1:0] : s2_data_q;
    mc_valid_d = mc_valid_q;
    mc_cnt_d   = mc_cnt_q;
    mc_data_d  = mc_data_q;
    if (accept && (apu_slave_lat_i == 2'd3)) begin
      mc_valid_d = 1'b1;
      mc_cnt_d   = MCW'(MC_CYCLES - 1);
      mc_data_d  = alu_ext[WIDTH-1:0];
    end else if (mc_valid_q) begin
      mc_cnt_d = mc_cnt_q - MCW'(1);
      if (push_mc) mc_valid_d = 1'b0;
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      mc_valid_q <= 1'b0;
      mc_data_q  <= '0;
      mc_cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      mc_valid_q <= mc_valid_d;
      mc_data_q  <= mc_data_d;
      mc_cnt_q   <= mc_cnt_d;
      mem_q      <= mem_d;
    end
  end

  assign apu_slave_valid_o  = (count_q != '0);
  assign apu_slave_result_o = apu_slave_valid_o ? mem_q[rd_ptr_q] : '0;
  assign busy_o             = (occupancy != '0);

`ifdef APU_RESP_FLAGS_EN
  logic [1:0] flg_q [DEPTH];
  logic [1:0] flg_d [DEPTH];
  logic [1:0] s2_flg_q, s2_flg_d, mc_flg_q, mc_flg_d, new_flg, push_flg;

  always_comb begin
    new_flg[0] = (alu_ext[WIDTH-1:0] == '0);
    new_flg[1] = !apu_slave_op_i[1] && alu_ext[WIDTH];
    s2_flg_d   = s2_valid_d ? new_flg : s2_flg_q;
    mc_flg_d   = (accept && (apu_slave_lat_i == 2'd3)) ? new_flg : mc_flg_q;
    if (push_s2)      push_flg = s2_flg_q;
    else if (push_mc) push_flg = mc_flg_q;
    else              push_flg = new_flg;
    flg_d = flg_q;
    if (push) flg_d[wr_ptr_q] = push_flg;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_flg_q <= '0;
      mc_flg_q <= '0;
      for (int i = 0; i < DEPTH; i++) flg_q[i] <= '0;
    end else begin
      s2_flg_q <= s2_flg_d;
      mc_flg_q <= mc_flg_d;
      flg_q    <= flg_d;
    end
  end

  assign apu_slave_flags_o = apu_slave_valid_o ? flg_q[rd_ptr_q] : 2'b00;
`endif

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && (count_q == CW'(DEPTH))));
  a_one_push: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0({push_direct, push_s2, push_mc}));

endmodule
